// File: rtl/weight_stream_loader_pkg.sv
// weight_stream_loader_pkg: shared widths, per-layer weight regions and the beat-to-byte shift helper
package weight_stream_loader_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_SIZE_DEF = 32;
  localparam int LEN_WIDTH_DEF = 10;
  localparam logic [31:0] CONV1_W_BASE = 32'h0010_0000;
  localparam int CONV1_W_WORDS = 600;
  localparam logic [31:0] CONV2_W_BASE = 32'h0011_0000;
  localparam int CONV2_W_WORDS = 4608;
  localparam logic [31:0] FC1_W_BASE = 32'h0020_0000;
  localparam int FC1_W_WORDS = 16384;
  function automatic int beat_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction
endpackage

// File: rtl/weight_sfifo.sv
// weight_sfifo: synchronous first-word-fall-through FIFO with async reset and synchronous clear
module weight_sfifo
  import weight_stream_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          s_clk,
  input  logic                          s_rst,
  input  logic                          srst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge s_clk)
    if (wr_en && !srst) mem_q[wp_q] <= din;
  always_ff @(posedge s_clk or posedge s_rst)
    if (s_rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else if (srst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(wr_en);
      rp_q <= rp_q + AW'(rd_en);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign dout = empty ? '0 : mem_q[rp_q];
endmodule

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: streams a DDR weight region (base, words, passes) in reserved bursts through a FIFO to a PE array
module weight_stream_loader
  import weight_stream_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int LEN_WIDTH = LEN_WIDTH_DEF,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_WIDTH = 20
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  cfg_start,
  input  logic [ADDR_SIZE-1:0]  cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_total_words,
  input  logic [7:0]            cfg_passes,
  output logic                  rd_burst_req,
  output logic [ADDR_SIZE-1:0]  rd_burst_addr,
  output logic [LEN_WIDTH-1:0]  rd_burst_len,
  input  logic [DATA_WIDTH-1:0] rd_burst_data,
  input  logic                  rd_burst_valid,
  input  logic                  rd_burst_finish,
  output logic [DATA_WIDTH-1:0] o_weight_out,
  output logic                  o_weight_valid,
  input  logic                  weight_ready,
  input  logic                  abort,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT_FIN = 3'd2, DRAIN = 3'd3, FLUSH = 3'd4;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = CNT_WIDTH + 8;
  localparam int SHIFT = beat_shift(DATA_WIDTH);
  logic [2:0] state_q, state_d;
  logic [ADDR_SIZE-1:0] base_q, base_d, addr_q, addr_d;
  logic [CNT_WIDTH-1:0] total_q, total_d, left_q, left_d;
  logic [7:0] pass_q, pass_d;
  logic [TW-1:0] target_q, target_d, deliv_q, deliv_d;
  logic [CW-1:0] resv_q, resv_d, count;
  logic [LEN_WIDTH-1:0] len_q, len_d, len_c;
  logic req_q, req_d, done_q, done_d;
  logic full, empty, wr, xfer, clr, issue, last_xfer, aborting;
  logic [CW:0] space;
  assign len_c = left_q < CNT_WIDTH'(BURST_LEN) ? LEN_WIDTH'(left_q) : LEN_WIDTH'(BURST_LEN);
  assign space = (CW+1)'(FIFO_DEPTH) - ({1'b0, count} + {1'b0, resv_q});
  assign aborting = abort && state_q != IDLE;
  assign issue = state_q == REQ && !abort && 32'(space) >= 32'(len_c);
  assign wr = rd_burst_valid && state_q != IDLE && state_q != FLUSH;
  assign xfer = o_weight_valid && weight_ready;
  // The final word is recognised from the running delivery count so o_done lines up with that transfer.
  assign last_xfer = xfer && !aborting && state_q != IDLE && state_q != FLUSH && deliv_q == target_q - 1'b1;
  assign clr = aborting || (state_q == FLUSH && rd_burst_finish);
  assign o_done = done_q || last_xfer;
  assign o_busy = state_q != IDLE;
  assign rd_burst_req = req_q;
  assign rd_burst_addr = addr_q;
  assign rd_burst_len = len_q;
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    addr_d = addr_q;
    total_d = total_q;
    left_d = left_q;
    pass_d = pass_q;
    target_d = target_q;
    len_d = len_q;
    req_d = req_q;
    done_d = 1'b0;
    deliv_d = deliv_q + TW'(xfer);
    resv_d = aborting ? '0 : resv_q + (issue ? CW'(len_c) : '0) - CW'(wr);
    case (state_q)
      IDLE: if (cfg_start && !abort) begin
        base_d = cfg_base_addr;
        addr_d = cfg_base_addr;
        total_d = cfg_total_words;
        left_d = cfg_total_words;
        pass_d = cfg_passes == 8'd0 ? 8'd1 : cfg_passes;
        target_d = TW'(cfg_total_words) * TW'(pass_d);
        deliv_d = '0;
        done_d = cfg_total_words == '0;
        state_d = cfg_total_words == '0 ? IDLE : REQ;
      end
      REQ:
        if (aborting) state_d = IDLE;
        else if (issue) begin
          req_d = 1'b1;
          len_d = len_c;
          state_d = WAIT_FIN;
        end
      WAIT_FIN:
        if (aborting) begin
          req_d = rd_burst_finish ? 1'b0 : req_q;
          state_d = rd_burst_finish ? IDLE : FLUSH;
        end else if (rd_burst_finish) begin
          req_d = 1'b0;
          addr_d = addr_q + (ADDR_SIZE'(len_q) << SHIFT);
          left_d = left_q - CNT_WIDTH'(len_q);
          state_d = REQ;
          if (left_d == '0 && pass_q > 8'd1) begin
            pass_d = pass_q - 8'd1;
            addr_d = base_q;
            left_d = total_q;
          end else if (left_d == '0) state_d = DRAIN;
        end
      DRAIN: if (aborting || last_xfer || (empty && deliv_q == target_q)) state_d = IDLE;
      FLUSH: if (rd_burst_finish) begin
        req_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_clk or posedge s_rst)
    if (s_rst) begin
      state_q <= IDLE;
      base_q <= '0;
      addr_q <= '0;
      total_q <= '0;
      left_q <= '0;
      pass_q <= '0;
      target_q <= '0;
      deliv_q <= '0;
      resv_q <= '0;
      len_q <= '0;
      req_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      addr_q <= addr_d;
      total_q <= total_d;
      left_q <= left_d;
      pass_q <= pass_d;
      target_q <= target_d;
      deliv_q <= deliv_d;
      resv_q <= resv_d;
      len_q <= len_d;
      req_q <= req_d;
      done_q <= done_d;
    end
  weight_sfifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .s_clk(s_clk),
    .s_rst(s_rst),
    .srst(clr),
    .wr_en(wr && (!full || xfer)),
    .din(rd_burst_data),
    .rd_en(xfer),
    .dout(o_weight_out),
    .count(count),
    .full(full),
    .empty(empty)
  );
  assign o_weight_valid = !empty;
endmodule

// File: tb/tb_weight_stream_loader.sv
// tb_weight_stream_loader: randomized scoreboard bench with a DDR burst responder and a word-order reference model
module tb_weight_stream_loader;
  localparam int DW = 64, AS = 32, LW = 10, BL = 16, FD = 64, CW = 20;
  logic s_clk, s_rst, cfg_start, rd_burst_req, rd_burst_valid, rd_burst_finish;
  logic o_weight_valid, weight_ready, abort, o_busy, o_done;
  logic [AS-1:0] cfg_base_addr, rd_burst_addr;
  logic [CW-1:0] cfg_total_words;
  logic [7:0] cfg_passes;
  logic [LW-1:0] rd_burst_len;
  logic [DW-1:0] rd_burst_data, o_weight_out;
  int checks = 0, fails = 0, done_cnt = 0, exp_done = 0, n_req = 0, beat_idx = -1, rmode = 0;
  bit kill = 0, ddr_busy = 0;
  logic [DW-1:0] exp_q[$];
  bit last_q[$];
  logic [AS-1:0] eba_q[$];
  int ebl_q[$];

  weight_stream_loader #(.DATA_WIDTH(DW), .ADDR_SIZE(AS), .LEN_WIDTH(LW), .BURST_LEN(BL),
                         .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
    .s_clk(s_clk), .s_rst(s_rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_total_words(cfg_total_words), .cfg_passes(cfg_passes), .rd_burst_req(rd_burst_req),
    .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len), .rd_burst_data(rd_burst_data),
    .rd_burst_valid(rd_burst_valid), .rd_burst_finish(rd_burst_finish), .o_weight_out(o_weight_out),
    .o_weight_valid(o_weight_valid), .weight_ready(weight_ready), .abort(abort), .o_busy(o_busy),
    .o_done(o_done)
  );

  initial begin
    s_clk = 0;
    forever #5 s_clk = ~s_clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at 600000, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] word_at(input logic [AS-1:0] a);
    return {a ^ 32'h5A5A_A5A5, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    last_q.delete();
    eba_q.delete();
    ebl_q.delete();
  endtask

  task automatic start_job(input logic [AS-1:0] base, input int total, input int passes);
    int p = passes == 0 ? 1 : passes;
    for (int pp = 0; pp < p; pp++) begin
      for (int i = 0; i < total; i++) begin
        exp_q.push_back(word_at(base + 32'(i * 8)));
        last_q.push_back(pp == p - 1 && i == total - 1);
      end
      for (int off = 0; off < total; off += BL) begin
        eba_q.push_back(base + 32'(off * 8));
        ebl_q.push_back(total - off < BL ? total - off : BL);
      end
    end
    exp_done++;
    @(posedge s_clk); #1;
    cfg_start = 1;
    cfg_base_addr = base;
    cfg_total_words = CW'(total);
    cfg_passes = 8'(passes);
    @(posedge s_clk); #1;
    cfg_start = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((o_busy || ddr_busy || exp_q.size() != 0) && n < 6000) begin
      @(negedge s_clk);
      n++;
    end
    checks++;
    if (n >= 6000) begin
      fails++;
      $display("FAIL %s_timeout: busy=%0b words_pending=%0d, required idle within 6000 cycles", name, o_busy, exp_q.size());
    end
    check({name, "_done_count"}, 64'(done_cnt), 64'(exp_done));
    check({name, "_bursts_left"}, 64'(eba_q.size()), 64'd0);
  endtask

  task automatic wait_beat(input int idx);
    int n = 0;
    while (beat_idx != idx && n < 500) begin
      @(posedge s_clk); #2;
      n++;
    end
    check("beat_reached", 64'(beat_idx), 64'(idx));
  endtask

  initial begin
    weight_ready = 1;
    forever begin
      @(posedge s_clk); #1;
      case (rmode)
        0: weight_ready = 1;
        1: weight_ready = $urandom_range(0, 2) == 0;
        2: weight_ready = 0;
        default: weight_ready = $urandom_range(0, 1) == 1;
      endcase
    end
  end

  initial begin
    logic [AS-1:0] a, ea;
    int l, el;
    bit fin_last;
    rd_burst_valid = 0;
    rd_burst_finish = 0;
    rd_burst_data = '0;
    forever begin
      @(negedge s_clk);
      if (rd_burst_req && !s_rst) begin
        a = rd_burst_addr;
        l = int'(rd_burst_len);
        n_req++;
        ddr_busy = 1;
        checks++;
        if (eba_q.size() == 0) begin
          fails++;
          $display("FAIL burst_req: got addr %h len %0d, required no request", a, l);
        end else begin
          ea = eba_q.pop_front();
          el = ebl_q.pop_front();
          if (a !== ea || l != el) begin
            fails++;
            $display("FAIL burst_req: got addr %h len %0d, required addr %h len %0d", a, l, ea, el);
          end
        end
        fin_last = $urandom_range(0, 1) == 1;
        repeat ($urandom_range(0, 2)) @(posedge s_clk);
        for (int i = 0; i < l; i++) begin
          @(posedge s_clk); #1;
          if (kill) break;
          if ($urandom_range(0, 3) == 0) begin
            rd_burst_valid = 0;
            @(posedge s_clk); #1;
            if (kill) break;
          end
          rd_burst_valid = 1;
          rd_burst_data = word_at(a + 32'(i * 8));
          beat_idx = i;
          rd_burst_finish = fin_last && i == l - 1;
        end
        if (!kill && !fin_last) begin
          @(posedge s_clk); #1;
          rd_burst_valid = 0;
          rd_burst_finish = 1;
        end
        @(posedge s_clk); #1;
        rd_burst_valid = 0;
        rd_burst_finish = 0;
        beat_idx = -1;
        ddr_busy = 0;
      end
    end
  end

  initial begin
    logic stall_q = 0, prev_abort = 0;
    logic [DW-1:0] prev_out = '0, e;
    bit lst;
    forever begin
      @(negedge s_clk);
      if (s_rst) stall_q = 0;
      else begin
        if (stall_q && !prev_abort) check("hold_stable", o_weight_valid ? o_weight_out : ~prev_out, prev_out);
        if (o_weight_valid && weight_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL word: got %h done=%0b, required no transfer", o_weight_out, o_done);
          end else begin
            e = exp_q.pop_front();
            lst = last_q.pop_front();
            if (o_weight_out !== e || o_done !== lst) begin
              fails++;
              $display("FAIL word: got %h done=%0b, required %h done=%0b", o_weight_out, o_done, e, lst);
            end
          end
        end
        if (o_done) done_cnt++;
        if (dut.wr) begin
          checks++;
          if (dut.full && !(o_weight_valid && weight_ready)) begin
            fails++;
            $display("FAIL overflow: beat written with full=1, required free space");
          end
        end
        stall_q = o_weight_valid && !weight_ready;
        prev_out = o_weight_out;
        prev_abort = abort;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(rd_burst_req), 64'd0);
    check({tag, "_addr"}, 64'(rd_burst_addr), 64'd0);
    check({tag, "_len"}, 64'(rd_burst_len), 64'd0);
    check({tag, "_valid"}, 64'(o_weight_valid), 64'd0);
    check({tag, "_out"}, o_weight_out, 64'd0);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_done"}, 64'(o_done), 64'd0);
  endtask

  initial begin
    int r0, d0, n, r, tot, pas;
    logic [AS-1:0] base;
    s_rst = 1;
    cfg_start = 0;
    cfg_base_addr = '0;
    cfg_total_words = '0;
    cfg_passes = '0;
    abort = 0;
    repeat (3) @(negedge s_clk);
    check_reset_outputs("reset");
    s_rst = 0;
    repeat (2) @(negedge s_clk);

    rmode = 0;
    start_job(32'h1000, 40, 1);
    @(negedge s_clk);
    check("req_latency_early", 64'(rd_burst_req), 64'd0);
    @(negedge s_clk);
    check("req_latency", 64'(rd_burst_req), 64'd1);
    wait_idle("job40");

    rmode = 2;
    start_job(32'h8000, 16, 3);
    repeat (200) @(negedge s_clk);
    check("held_all_requested", 64'(eba_q.size()), 64'd0);
    check("held_valid", 64'(o_weight_valid), 64'd1);
    check("held_busy", 64'(o_busy), 64'd1);
    rmode = 0;
    wait_idle("passes3");

    rmode = 1;
    start_job(32'h2_0000, 200, 1);
    wait_idle("ready_1of3");

    for (int j = 0; j < 6; j++) begin
      r = $urandom_range(0, 2);
      rmode = r == 2 ? 3 : r;
      base = $urandom & 32'hFFFF_FFF8;
      tot = $urandom_range(1, 90);
      pas = $urandom_range(0, 3);
      start_job(base, tot, pas);
      wait_idle("random");
    end

    rmode = 0;
    r0 = n_req;
    d0 = done_cnt;
    exp_done++;
    @(posedge s_clk); #1;
    cfg_start = 1;
    cfg_base_addr = 32'h4000;
    cfg_total_words = '0;
    cfg_passes = 8'd2;
    @(posedge s_clk); #1;
    cfg_start = 0;
    @(negedge s_clk);
    check("zero_done", 64'(o_done), 64'd1);
    @(negedge s_clk);
    check("zero_done_pulse", 64'(o_done), 64'd0);
    repeat (5) @(negedge s_clk);
    check("zero_no_req", 64'(n_req), 64'(r0));
    check("zero_idle", 64'(o_busy), 64'd0);
    check("zero_done_count", 64'(done_cnt), 64'(d0 + 1));

    @(posedge s_clk); #1;
    cfg_start = 1;
    abort = 1;
    cfg_total_words = CW'(10);
    @(posedge s_clk); #1;
    cfg_start = 0;
    abort = 0;
    repeat (4) @(negedge s_clk);
    check("abort_wins_idle", 64'(o_busy), 64'd0);
    check("abort_wins_no_req", 64'(n_req), 64'(r0));

    d0 = done_cnt;
    start_job(32'h6000, 64, 1);
    exp_done--;
    wait_beat(5);
    abort = 1;
    @(posedge s_clk); #1;
    abort = 0;
    clear_model();
    n = 0;
    while ((ddr_busy || o_busy) && n < 500) begin
      @(negedge s_clk);
      n++;
    end
    @(negedge s_clk);
    check("abort_valid", 64'(o_weight_valid), 64'd0);
    check("abort_idle", 64'(o_busy), 64'd0);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    start_job(32'h7000, 33, 2);
    wait_idle("after_abort");

    d0 = done_cnt;
    start_job(32'h9000, 64, 1);
    exp_done--;
    wait_beat(3);
    @(negedge s_clk);
    s_rst = 1;
    kill = 1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge s_clk);
    n = 0;
    while (ddr_busy && n < 50) begin
      @(negedge s_clk);
      n++;
    end
    clear_model();
    s_rst = 0;
    kill = 0;
    repeat (5) @(negedge s_clk);
    check("post_rst_valid", 64'(o_weight_valid), 64'd0);
    check("post_rst_busy", 64'(o_busy), 64'd0);
    check("post_rst_req", 64'(rd_burst_req), 64'd0);
    check("post_rst_no_done", 64'(done_cnt), 64'(d0));

    rmode = 3;
    start_job(32'hA000, 20, 1);
    wait_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
